// File: rtl/rs232_rx_fifo.sv
// rs232_rx_fifo
//   Byte FIFO placed behind an RS232 receiver. The receiver cannot be
//   stalled, so bytes arriving while the FIFO is full are dropped and a
//   sticky overflow flag records the loss. The head byte is held in an
//   output register (show-ahead), so out_data/out_valid are registered
//   and valid one cycle after a push into an empty FIFO.
//
// Ports
//   clock          system clock, rising edge
//   resetn         synchronous active-low reset
//   in_data        received byte
//   in_valid       one-cycle strobe, in_data carries a new byte
//   out_data       head-of-FIFO byte (registered, holds while empty)
//   out_valid      out_data holds a valid byte (registered)
//   out_ready      consumer accepts out_data when out_valid && out_ready
//   level          number of stored bytes, 0 .. 2**DEPTH_LOG2
//   overflow       sticky: at least one byte was dropped
//   clear_overflow one-cycle request to clear overflow (a drop wins)
module rs232_rx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  clear_overflow
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [DEPTH_LOG2:0] ONE_LEVEL  = LW'(1);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr_next;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic [DEPTH_LOG2:0]   level_next;
    logic [7:0]            data_next;

    always_comb begin
        full        = (level == FULL_LEVEL);
        pop         = out_valid && out_ready;
        // A pop frees the head slot this cycle, so a full FIFO still accepts.
        push        = in_valid && (!full || pop);
        drop        = in_valid && full && !pop;
        rd_ptr_next = rd_ptr + 1'b1;

        level_next = level;
        if (push && !pop) begin
            level_next = level + 1'b1;
        end else if (pop && !push) begin
            level_next = level - 1'b1;
        end

        // The head lives in mem[rd_ptr] and is mirrored in out_data. After a
        // pop the next head comes from memory if one is stored, otherwise
        // from the byte being pushed in the same cycle. The slot read here
        // can never be the one written this cycle: wr_ptr == rd_ptr + level.
        data_next = out_data;
        if (pop) begin
            if (level != ONE_LEVEL) begin
                data_next = mem[rd_ptr_next];
            end else if (push) begin
                data_next = in_data;
            end
        end else if (push && level == '0) begin
            data_next = in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (resetn && push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_next;
            end
            level     <= level_next;
            out_valid <= (level_next != '0);
            out_data  <= data_next;
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rs232_rx_fifo.md
RS232_RX_FIFO -- requirements
Module: rs232_rx_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4: FIFO depth is 2**DEPTH_LOG2 bytes (16 by default). Legal range 2..8.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 in_data  input  8  received byte, from the RS232 receiver data output.
REQ-005 in_valid  input  1  one-cycle strobe: in_data holds a new byte. No backpressure toward the receiver.
REQ-006 out_data  output  8  head-of-FIFO byte, registered.
REQ-007 out_valid  output  1  out_data holds a valid byte, registered.
REQ-008 out_ready  input  1  consumer accepts out_data in any cycle where out_valid && out_ready.
REQ-009 level  output  DEPTH_LOG2+1  number of stored bytes, registered, range 0..2**DEPTH_LOG2.
REQ-010 overflow  output  1  sticky flag: at least one byte was dropped.
REQ-011 clear_overflow  input  1  one-cycle request to clear overflow.

Function
REQ-012 Storage: circular buffer with write and read pointers of DEPTH_LOG2 bits. Pointers wrap modulo depth.
REQ-013 Full/empty: decided from level only.
  - empty: level == 0.
  - full: level == 2**DEPTH_LOG2.
REQ-014 Push: in_valid && !full stores in_data at the write pointer and advances the write pointer by 1.
REQ-015 Pop: out_valid && out_ready consumes the head and advances the read pointer by 1.
REQ-016 Level update per cycle:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - neither: unchanged.
REQ-017 Full with simultaneous pop: a push in the same cycle as a pop while full is accepted. Level stays at full and no byte is dropped.
REQ-018 Drop on full: in_valid while full with no pop drops the byte. Level, pointers and stored data are unchanged, and overflow is set on the next edge.
REQ-019 Overflow priority: overflow clears when clear_overflow is asserted. If a drop occurs in the same cycle, set wins and overflow remains 1.
REQ-020 Latency, push to empty FIFO: out_valid and out_data become valid on the first rising edge after the push cycle (1-cycle latency). No combinational path from in_* to out_*.
REQ-021 Show-ahead behaviour: after a pop with further bytes stored, the next byte appears on out_data with out_valid held high in the following cycle. Sustained throughput is one byte per cycle.
REQ-022 Last byte popped: when the last byte is popped and no push occurs, out_valid drops to 0 on the next edge.
REQ-023 Push and pop on the last byte: when the last byte is popped in the same cycle as a push, out_valid stays 1 and out_data shows the new byte on the next edge.
REQ-024 out_data when empty: while out_valid == 0, out_data retains its previous value.
REQ-025 Hold under stall: out_data shall not change while out_valid && !out_ready.
REQ-026 Byte order: bytes are delivered strictly in arrival order. Dropped bytes never appear at the output.
REQ-027 Output view: level and out_valid are mutually consistent every cycle, i.e. out_valid == (level != 0) from the registered view.

Reset
REQ-028 Reset values: while resetn == 0 at a rising edge, the following are cleared on that edge regardless of all other inputs:
  - write and read pointers = 0.
  - level = 0.
  - out_valid = 0.
  - out_data = 8'h00.
  - overflow = 0.
REQ-029 Reset mid-operation: reset asserted mid-operation discards all stored bytes. No output handshake occurs in the reset cycle.
REQ-030 Memory contents: buffer memory needs no reset. Stale contents shall never be presented with out_valid == 1.
REQ-031 First push after reset: accepted on the first edge with resetn == 1.

Verification
REQ-032 Single byte: push 8'hA5 with out_ready = 1 -> next cycle out_valid = 1 and out_data = A5, consumed in that cycle; following cycle out_valid = 0, level = 0.
REQ-033 Fill and drain: with out_ready = 0, push 8'h00..8'h0F (16 bytes) -> level = 16, overflow = 0. Then out_ready = 1 -> bytes 00..0F emerge on 16 consecutive cycles, then level = 0.
REQ-034 Overflow drop:
  - stimulus: FIFO full at 00..0F, out_ready = 0, push 8'hEE.
  - response: overflow = 1, level = 16; after draining, the output sequence is 00..0F with no EE.
  - then pulse clear_overflow -> overflow = 0.
REQ-035 Full with simultaneous pop: FIFO full, out_ready = 1 and push 8'h55 in the same cycle -> level stays 16, no overflow, and 55 is the 16th byte out after the current head.
REQ-036 Set-over-clear: full, no pop, in_valid and clear_overflow asserted together -> overflow = 1.
REQ-037 Reset mid-stream: 5 bytes stored, resetn low one cycle -> level = 0, out_valid = 0, out_data = 00, overflow = 0. Next push 8'h3C is the first byte out.
